// File: rtl/uart_rx_ctrl_if.sv
// Bundle between uart_rx_ctrl, the UART receiver and the downstream drain port.
// The idle_timeout signal exists only when UART_RX_CTRL_TIMEOUT_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Receiver side: rx_data is valid while rx_rdy=1; rx_rdy_clr is a one-cycle
  // acknowledge, and the receiver lowers rx_rdy after seeing it.
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_rdy_clr;

  // Drain side: a byte moves on every clock edge where out_valid && out_ready.
  // out_valid never depends on out_ready, and out_data holds until that edge.
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;

  logic [CW-1:0] count;
  logic          overrun;
  logic          ovr_clr;
  logic [7:0]    drop_cnt;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic          idle_timeout;

  modport slave (
    input  rx_rdy, rx_data, out_ready, ovr_clr,
    output rx_rdy_clr, out_valid, out_data, count, overrun, drop_cnt, idle_timeout
  );
  modport master (
    output rx_rdy, rx_data, out_ready, ovr_clr,
    input  rx_rdy_clr, out_valid, out_data, count, overrun, drop_cnt, idle_timeout
  );
`else
  modport slave (
    input  rx_rdy, rx_data, out_ready, ovr_clr,
    output rx_rdy_clr, out_valid, out_data, count, overrun, drop_cnt
  );
  modport master (
    output rx_rdy, rx_data, out_ready, ovr_clr,
    input  rx_rdy_clr, out_valid, out_data, count, overrun, drop_cnt
  );
`endif
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: rx_rdy/rx_rdy_clr handshake, byte FIFO, overrun tracking.
// Optional inter-byte idle timeout is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 640
) (
  input  logic              clk_16x_bps,
  input  logic              rst,
  uart_rx_ctrl_if.slave     bus,
  output logic [1:0]        fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_ctrl: DEPTH must be a power of two in 2..64");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("uart_rx_ctrl: TIMEOUT_CYC must fit the 16-bit idle counter");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          capture;
  logic          clr_nxt;
  logic          rdy_clr_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          empty, full, push, pop, drop;
  logic          overrun_q;
  logic [7:0]    drop_q;

  // Handshake FSM
  always_ff @(posedge clk_16x_bps or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rdy_clr_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rdy_clr_q <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    clr_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.rx_rdy) begin
          capture   = 1'b1;
          clr_nxt   = 1'b1;
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR:    state_nxt = ST_WAIT_LOW;
      // Hold here so a still-high rx_rdy is never captured twice.
      ST_WAIT_LOW: if (!bus.rx_rdy) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // FIFO control: a full FIFO still accepts a byte if the head leaves on the same edge.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = !empty && bus.out_ready;
  assign push  = capture && (!full || pop);
  assign drop  = capture && full && !pop;

  always_ff @(posedge clk_16x_bps) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk_16x_bps or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Clearing wins over a drop on the same edge; that drop goes uncounted.
  always_ff @(posedge clk_16x_bps or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      drop_q    <= 8'd0;
    end else if (bus.ovr_clr) begin
      overrun_q <= 1'b0;
      drop_q    <= 8'd0;
    end else if (drop) begin
      overrun_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);
  logic [15:0] idle_cnt;

  // Counter parks at the limit, which holds idle_timeout until a capture or an empty FIFO.
  always_ff @(posedge clk_16x_bps or posedge rst) begin
    if (rst) begin
      idle_cnt <= 16'd0;
    end else if (capture || empty) begin
      idle_cnt <= 16'd0;
    end else if (idle_cnt != TO_LIMIT) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign bus.idle_timeout = (idle_cnt == TO_LIMIT);
`endif

  assign bus.rx_rdy_clr = rdy_clr_q;
  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? 8'h00 : mem[rd_ptr];
  assign bus.count      = count_q;
  assign bus.overrun    = overrun_q;
  assign bus.drop_cnt   = drop_q;
  assign fsm_state      = state;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl: a queue model of the byte FIFO checks every cycle.
// Define UART_RX_CTRL_TIMEOUT_EN to also exercise the idle timeout.
module tb_uart_rx_ctrl;
  localparam int DEPTH       = 8;
  localparam int CW          = $clog2(DEPTH) + 1;
  localparam int TIMEOUT_CYC = 640;

  // ---------------- clock / reset ----------------
  logic       clk_16x_bps = 1'b0;
  logic       rst         = 1'b1;
  logic [1:0] fsm_state;

  always #5 clk_16x_bps = ~clk_16x_bps;

  uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_16x_bps (clk_16x_bps),
    .rst         (rst),
    .bus         (bus),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  bit         m_ovr = 1'b0;
  int         m_drop = 0;
  bit         cap_done = 1'b0;
  int         caps = 0;
  int         clr_hi = 0;
  int         pops = 0;
  logic [7:0] last_pop = 8'h00;
  int         cyc = 0;
  int         cap_cyc = 0;
  bit         rand_ready = 1'b0;

  always @(posedge clk_16x_bps) cyc <= cyc + 1;

  // Model: every rx_rdy rise (or rx_rdy high at reset release) is one byte offered.
  // It joins the queue if there is room after this edge's pop, else it counts as a drop.
  always @(negedge clk_16x_bps) begin
    #1;
    if (rst) begin
      exp_q.delete();
      m_ovr    = 1'b0;
      m_drop   = 0;
      cap_done = 1'b0;
    end else begin
      if (bus.rx_rdy_clr) clr_hi++;
      checks++;
      if (bus.count !== CW'(exp_q.size())) begin
        errors++; $display("FAIL count t=%0t got=%0d exp=%0d", $time, bus.count, exp_q.size());
      end
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL out_valid t=%0t got=%0b exp=%0b", $time, bus.out_valid, exp_q.size() != 0);
      end
      checks++;
      if (bus.overrun !== m_ovr || bus.drop_cnt !== 8'(m_drop)) begin
        errors++; $display("FAIL overrun/drop_cnt t=%0t got=%0b/%0d exp=%0b/%0d",
                           $time, bus.overrun, bus.drop_cnt, m_ovr, m_drop);
      end
      if (exp_q.size() == 0) begin
        checks++;
        if (bus.out_data !== 8'h00) begin
          errors++; $display("FAIL empty_out_data t=%0t got=%h exp=00", $time, bus.out_data);
        end
      end else if (bus.out_ready) begin
        checks++;
        if (bus.out_data !== exp_q[0]) begin
          errors++; $display("FAIL pop_data t=%0t got=%h exp=%h", $time, bus.out_data, exp_q[0]);
        end
        last_pop = exp_q.pop_front();
        pops++;
      end
      if (bus.rx_rdy && !cap_done) begin
        cap_done = 1'b1;
        caps++;
        cap_cyc = cyc + 1;
        if (exp_q.size() < DEPTH) exp_q.push_back(bus.rx_data);
        else if (!bus.ovr_clr) begin
          m_ovr = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (!bus.rx_rdy) cap_done = 1'b0;
      if (bus.ovr_clr) begin
        m_ovr  = 1'b0;
        m_drop = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_16x_bps);
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Receiver behaviour: raise rx_rdy, wait for the clear strobe, drop rx_rdy one edge later.
  task automatic send_byte(input logic [7:0] b, input bit pop_now);
    int n;
    tick();
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    if (pop_now) bus.out_ready = 1'b1;
    tick();
    if (pop_now) bus.out_ready = 1'b0;
    n = 0;
    while (!bus.rx_rdy_clr && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.rx_rdy_clr !== 1'b1) begin
      errors++; $display("FAIL rx_rdy_clr_timeout byte=%h got=%b exp=1", b, bus.rx_rdy_clr);
    end
    tick();
    bus.rx_rdy = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * DEPTH) begin
      tick();
      n++;
    end
    tick();
    bus.out_ready = 1'b0;
    tick();
    checks++;
    if (bus.count !== '0) begin
      errors++; $display("FAIL drain_count got=%0d exp=0", bus.count);
    end
  endtask

  task automatic pulse_ovr_clr();
    tick();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (bus.rx_rdy_clr !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.count !== '0 || bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd0 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL reset_values got clr=%b v=%b d=%h c=%0d o=%b dc=%0d st=%0d exp all zero",
                         bus.rx_rdy_clr, bus.out_valid, bus.out_data, bus.count, bus.overrun,
                         bus.drop_cnt, fsm_state);
    end
`ifdef UART_RX_CTRL_TIMEOUT_EN
    checks++;
    if (bus.idle_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_idle_timeout got=%b exp=0", bus.idle_timeout);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    int c0;
    c0 = clr_hi;
    send_byte(8'hA5, 1'b0);
    checks++;
    if (clr_hi - c0 != 1) begin
      errors++; $display("FAIL single_clr_pulses got=%0d exp=1", clr_hi - c0);
    end
    checks++;
    if (bus.count !== CW'(1) || bus.out_data !== 8'hA5 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_head got c=%0d d=%h v=%b exp c=1 d=a5 v=1",
                         bus.count, bus.out_data, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.count !== '0 || bus.out_data !== 8'h00) begin
      errors++; $display("FAIL single_pop got c=%0d d=%h exp c=0 d=00", bus.count, bus.out_data);
    end
  endtask

  task automatic test_fill_overrun();
    int p0;
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0);
    checks++;
    if (bus.count !== CW'(8) || bus.overrun !== 1'b1 || bus.drop_cnt !== 8'd2) begin
      errors++; $display("FAIL fill_status got c=%0d o=%b dc=%0d exp c=8 o=1 dc=2",
                         bus.count, bus.overrun, bus.drop_cnt);
    end
    p0 = pops;
    drain();
    checks++;
    if (pops - p0 != 8 || last_pop !== 8'h07) begin
      errors++; $display("FAIL fill_drain got pops=%0d last=%h exp pops=8 last=07", pops - p0, last_pop);
    end
    pulse_ovr_clr();
    checks++;
    if (bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL ovr_clr got o=%b dc=%0d exp o=0 dc=0", bus.overrun, bus.drop_cnt);
    end
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 260; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    checks++;
    if (bus.drop_cnt !== 8'd255 || bus.overrun !== 1'b1) begin
      errors++; $display("FAIL drop_saturate got dc=%0d o=%b exp dc=255 o=1", bus.drop_cnt, bus.overrun);
    end
    pulse_ovr_clr();
    // a drop coinciding with ovr_clr must not be counted
    bus.ovr_clr = 1'b1;
    send_byte(8'hEE, 1'b0);
    bus.ovr_clr = 1'b0;
    tick();
    checks++;
    if (bus.drop_cnt !== 8'd0 || bus.overrun !== 1'b0 || bus.count !== CW'(DEPTH)) begin
      errors++; $display("FAIL clr_priority got dc=%0d o=%b c=%0d exp dc=0 o=0 c=%0d",
                         bus.drop_cnt, bus.overrun, bus.count, DEPTH);
    end
    drain();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    send_byte(8'h3C, 1'b1);
    checks++;
    if (bus.count !== CW'(DEPTH) || bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      errors++; $display("FAIL full_pop got c=%0d o=%b dc=%0d exp c=%0d o=0 dc=0",
                         bus.count, bus.overrun, bus.drop_cnt, DEPTH);
    end
    drain();
    checks++;
    if (last_pop !== 8'h3C) begin
      errors++; $display("FAIL full_pop_last got=%h exp=3c", last_pop);
    end
  endtask

  task automatic test_wrap();
    int p0;
    p0 = pops;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    tick();
    bus.out_ready = 1'b0;
    tick();
    checks++;
    if (pops - p0 != 20 || bus.overrun !== 1'b0 || bus.count !== '0) begin
      errors++; $display("FAIL wrap got pops=%0d o=%b c=%0d exp pops=20 o=0 c=0",
                         pops - p0, bus.overrun, bus.count);
    end
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 6)) tick();
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b0;
    drain();
    pulse_ovr_clr();
  endtask

  task automatic test_reset_mid();
    int c0;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b0);
    tick();
    bus.rx_data = 8'h5A;
    bus.rx_rdy  = 1'b1;
    tick();
    checks++;
    if (bus.rx_rdy_clr !== 1'b1) begin
      errors++; $display("FAIL mid_in_clear got clr=%b exp=1", bus.rx_rdy_clr);
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.rx_rdy_clr !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.count !== '0 || bus.overrun !== 1'b0 || bus.drop_cnt !== 8'd0 || fsm_state !== 2'd0) begin
      errors++; $display("FAIL mid_reset_values got clr=%b v=%b d=%h c=%0d o=%b dc=%0d st=%0d exp all zero",
                         bus.rx_rdy_clr, bus.out_valid, bus.out_data, bus.count, bus.overrun,
                         bus.drop_cnt, fsm_state);
    end
    c0 = clr_hi;
    rst = 1'b0;
    repeat (8) tick();
    checks++;
    if (bus.count !== CW'(1) || bus.out_data !== 8'h5A || clr_hi - c0 != 1) begin
      errors++; $display("FAIL mid_recapture got c=%0d d=%h clr=%0d exp c=1 d=5a clr=1",
                         bus.count, bus.out_data, clr_hi - c0);
    end
    bus.rx_rdy = 1'b0;
    repeat (3) tick();
    drain();
  endtask

`ifdef UART_RX_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    send_byte(8'h77, 1'b0);
    while (cyc < cap_cyc + TIMEOUT_CYC - 1) tick();
    checks++;
    if (bus.idle_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early got=%b exp=0", bus.idle_timeout);
    end
    tick();
    checks++;
    if (bus.idle_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_set got=%b exp=1", bus.idle_timeout);
    end
    send_byte(8'h78, 1'b0);
    checks++;
    if (bus.idle_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_capture_clr got=%b exp=0", bus.idle_timeout);
    end
    n = 0;
    while (bus.idle_timeout !== 1'b1 && n < TIMEOUT_CYC + 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.idle_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_reset got=%b exp=1", bus.idle_timeout);
    end
    drain();
    tick();
    checks++;
    if (bus.idle_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_empty_clr got=%b exp=0", bus.idle_timeout);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.rx_rdy    = 1'b0;
    bus.rx_data   = 8'h00;
    bus.out_ready = 1'b0;
    bus.ovr_clr   = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_overrun();
    test_drop_saturate();
    test_full_pop();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
